// File: rtl/crc_pkg.sv
// Shared definitions for the multi-channel CRC engine: register map, CTRL
// field positions, transpose codes and reset values.
package crc_pkg;

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_POLY   = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int CTRL_TOT  = 30;
    localparam int CTRL_TOTR = 28;
    localparam int CTRL_FXOR = 26;
    localparam int CTRL_WAS  = 25;
    localparam int CTRL_TCRC = 24;

    localparam logic [31:0] CRC_RESET  = 32'hFFFF_FFFF;
    localparam logic [31:0] POLY_RESET = 32'h0000_1021;
    localparam logic [31:0] CTRL_RESET = 32'h0000_0000;

    localparam logic [0:0] ENG_IDLE = 1'b0;
    localparam logic [0:0] ENG_RUN  = 1'b1;

    typedef enum logic [1:0] {
        TP_NONE        = 2'b00,
        TP_BYTE_BITREV = 2'b01,
        TP_FULL_REV    = 2'b10,
        TP_BYTE_SWAP   = 2'b11
    } transpose_e;

    function automatic logic [31:0] transpose(input logic [31:0] w, input transpose_e code);
        logic [31:0] r;
        r = w;
        case (code)
            TP_BYTE_BITREV: for (int i = 0; i < 32; i++) r[i] = w[(i / 8) * 8 + 7 - (i % 8)];
            TP_FULL_REV:    for (int i = 0; i < 32; i++) r[i] = w[31 - i];
            TP_BYTE_SWAP:   r = {w[7:0], w[15:8], w[23:16], w[31:24]};
            default:        r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational STEP-bit advance of a 32- or 16-bit CRC register, message
// bits consumed MSB first, no augmentation.
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic [31:0]     crc_in,
    input  logic [31:0]     poly,
    input  logic [STEP-1:0] msg,
    input  logic            wide,
    output logic [31:0]     crc_out
);

    logic [31:0] c;
    logic        fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = STEP - 1; i >= 0; i--) begin
            fb = wide ? c[31] : c[15];
            c  = {c[30:0], msg[i]};
            if (fb) c = c ^ poly;
            if (!wide) c[31:16] = 16'h0000;
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc_engine_mc.sv
// NCH independent CRC contexts sharing one multi-cycle LFSR engine, with a
// one-word pending buffer and a ready/stall bus handshake.
module crc_engine_mc
    import crc_pkg::*;
#(
    parameter int          NCH       = 4,
    parameter int          STEP      = 8,
    parameter logic [31:0] BASE_ADDR = 32'h4003_2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        ready
);

    localparam int         CW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [4:0] CNT_LAST = 5'(32 / STEP - 1);

    logic [31:0] crc_q  [NCH];
    logic [31:0] poly_q [NCH];
    logic [31:0] ctrl_q [NCH];
    logic [15:0] wcnt_q [NCH];

    logic [0:0]    eng_state;
    logic [CW-1:0] eng_ctx;
    logic [4:0]    eng_cnt;
    logic [31:0]   eng_word;
    logic          buf_valid;
    logic [CW-1:0] buf_ctx;
    logic [31:0]   buf_word;

    logic [31:0]   offset;
    logic          mapped;
    logic [CW-1:0] ctx;
    logic [3:0]    reg_off;
    logic [31:0]   ctx_ctrl;
    logic          ctx_busy;
    logic          ctx_pend;
    logic          is_data;
    logic          stall_a;
    logic          stall_b;
    logic          wr_acc;
    logic          feed;
    logic [31:0]   in_word;
    logic [31:0]   lfsr_out;
    logic [31:0]   rd_crc;

    assign offset   = addr - BASE_ADDR;
    assign mapped   = (addr >= BASE_ADDR) && (offset < 32'(NCH * 16)) && (offset[1:0] == 2'b00);
    assign ctx      = offset[4 +: CW];
    assign reg_off  = offset[3:0];
    assign ctx_ctrl = ctrl_q[ctx];
    assign ctx_busy = (eng_state == ENG_RUN) && (eng_ctx == ctx);
    assign ctx_pend = buf_valid && (buf_ctx == ctx);
    assign is_data  = mapped && (reg_off == OFF_DATA);

    // Buffer-full stall looks only at registered state, so a drain and a
    // new buffered write never land on the same edge.
    assign stall_a = sel && rw && is_data && !ctx_ctrl[CTRL_WAS] && buf_valid;
    assign stall_b = sel && mapped && (reg_off != OFF_STATUS) && (ctx_busy || ctx_pend);
    assign ready   = !(rst && (stall_a || stall_b));

    assign wr_acc  = sel && ready && rw && mapped;
    assign feed    = wr_acc && is_data && !ctx_ctrl[CTRL_WAS];
    assign in_word = transpose(data_wr, transpose_e'(ctx_ctrl[CTRL_TOT +: 2]));

    crc_lfsr_step #(.STEP(STEP)) u_step (
        .crc_in  (crc_q[eng_ctx]),
        .poly    (poly_q[eng_ctx]),
        .msg     (eng_word[31 -: STEP]),
        .wide    (ctrl_q[eng_ctx][CTRL_TCRC]),
        .crc_out (lfsr_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                crc_q[i]  <= CRC_RESET;
                poly_q[i] <= POLY_RESET;
                ctrl_q[i] <= CTRL_RESET;
                wcnt_q[i] <= 16'h0000;
            end
            eng_state <= ENG_IDLE;
            eng_ctx   <= '0;
            eng_cnt   <= '0;
            eng_word  <= '0;
            buf_valid <= 1'b0;
            buf_ctx   <= '0;
            buf_word  <= '0;
        end else begin
            if (eng_state == ENG_RUN) begin
                crc_q[eng_ctx] <= lfsr_out;
                eng_word       <= eng_word << STEP;
                eng_cnt        <= eng_cnt + 5'd1;
                if (eng_cnt == CNT_LAST) begin
                    wcnt_q[eng_ctx] <= wcnt_q[eng_ctx] + 16'd1;
                    eng_cnt         <= '0;
                    // A write arriving on the last cycle hands straight over.
                    if (buf_valid) begin
                        eng_ctx   <= buf_ctx;
                        eng_word  <= buf_word;
                        buf_valid <= 1'b0;
                    end else if (feed) begin
                        eng_ctx  <= ctx;
                        eng_word <= in_word;
                    end else begin
                        eng_state <= ENG_IDLE;
                    end
                end else if (feed) begin
                    buf_valid <= 1'b1;
                    buf_ctx   <= ctx;
                    buf_word  <= in_word;
                end
            end else if (feed) begin
                eng_state <= ENG_RUN;
                eng_ctx   <= ctx;
                eng_word  <= in_word;
                eng_cnt   <= '0;
            end

            if (wr_acc) begin
                case (reg_off)
                    OFF_DATA: if (ctx_ctrl[CTRL_WAS]) begin
                        crc_q[ctx]  <= ctx_ctrl[CTRL_TCRC] ? in_word : {16'h0000, in_word[15:0]};
                        wcnt_q[ctx] <= 16'h0000;
                    end
                    OFF_POLY: poly_q[ctx] <= data_wr;
                    OFF_CTRL: ctrl_q[ctx] <= data_wr;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_crc = crc_q[ctx];
        if (ctx_ctrl[CTRL_FXOR])
            rd_crc = rd_crc ^ (ctx_ctrl[CTRL_TCRC] ? 32'hFFFF_FFFF : 32'h0000_FFFF);
        data_rd = '0;
        if (rst && sel && !rw && mapped) begin
            case (reg_off)
                OFF_DATA:   data_rd = transpose(rd_crc, transpose_e'(ctx_ctrl[CTRL_TOTR +: 2]));
                OFF_POLY:   data_rd = poly_q[ctx];
                OFF_CTRL:   data_rd = ctx_ctrl;
                OFF_STATUS: data_rd = {wcnt_q[ctx], 14'h0000, ctx_pend, ctx_busy};
                default:    data_rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_engine_mc.sv
// Scoreboard bench for crc_engine_mc: expectations are queued when stimulus
// is driven and popped when the matching bus read returns.
module tb_crc_engine_mc;

    localparam int          NCH  = 4;
    localparam int          STEP = 8;
    localparam int          LAT  = 32 / STEP;
    localparam logic [31:0] BASE = 32'h4003_2000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data_wr = '0;
    logic [31:0] data_rd;
    logic        ready;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    logic [31:0] m_crc [NCH];
    logic [31:0] m_poly[NCH];
    logic [31:0] m_ctrl[NCH];
    logic [15:0] m_cnt [NCH];

    always #5 clk = ~clk;

    crc_engine_mc #(.NCH(NCH), .STEP(STEP), .BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .rw      (rw),
        .addr    (addr),
        .data_wr (data_wr),
        .data_rd (data_rd),
        .ready   (ready)
    );

    function automatic logic [31:0] ra(input int c, input logic [3:0] off);
        return BASE + 32'(c * 16) + {28'h0, off};
    endfunction

    function automatic logic [31:0] tp(input logic [31:0] w, input logic [1:0] code);
        logic [31:0] r;
        r = w;
        case (code)
            2'b01: for (int b = 0; b < 4; b++) for (int i = 0; i < 8; i++) r[8*b+i] = w[8*b+7-i];
            2'b10: r = {<<{w}};
            2'b11: r = {<<8{w}};
            default: r = w;
        endcase
        return r;
    endfunction

    task automatic mdl_reset();
        for (int c = 0; c < NCH; c++) begin
            m_crc[c] = 32'hFFFF_FFFF;
            m_poly[c] = 32'h0000_1021;
            m_ctrl[c] = 32'h0;
            m_cnt[c] = 16'h0;
        end
    endtask

    task automatic mdl_write(input int c, input logic [3:0] off, input logic [31:0] d);
        logic [31:0] w;
        logic [31:0] r;
        logic [15:0] s;
        logic        fb;
        case (off)
            4'h4: m_poly[c] = d;
            4'h8: m_ctrl[c] = d;
            4'h0: begin
                w = tp(d, m_ctrl[c][31:30]);
                if (m_ctrl[c][25]) begin
                    m_crc[c] = m_ctrl[c][24] ? w : {16'h0, w[15:0]};
                    m_cnt[c] = 16'h0;
                end else begin
                    if (m_ctrl[c][24]) begin
                        r = m_crc[c];
                        for (int i = 31; i >= 0; i--) begin
                            fb = r[31];
                            r = {r[30:0], w[i]};
                            if (fb) r = r ^ m_poly[c];
                        end
                        m_crc[c] = r;
                    end else begin
                        s = m_crc[c][15:0];
                        for (int i = 31; i >= 0; i--) begin
                            fb = s[15];
                            s = {s[14:0], w[i]};
                            if (fb) s = s ^ m_poly[c][15:0];
                        end
                        m_crc[c] = {16'h0, s};
                    end
                    m_cnt[c] = m_cnt[c] + 16'd1;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] mdl_read(input int c, input logic [3:0] off);
        logic [31:0] r;
        case (off)
            4'h0: begin
                r = m_crc[c];
                if (m_ctrl[c][26]) r = r ^ (m_ctrl[c][24] ? 32'hFFFF_FFFF : 32'h0000_FFFF);
                return tp(r, m_ctrl[c][29:28]);
            end
            4'h4: return m_poly[c];
            4'h8: return m_ctrl[c];
            default: return {m_cnt[c], 16'h0};
        endcase
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int st);
        st = 0;
        sel = 1'b1; rw = 1'b1; addr = a; data_wr = d;
        #1;
        while (ready !== 1'b1 && st < 200) begin
            st++;
            @(negedge clk); #1;
        end
        if (st >= 200) begin
            total++; bad++;
            $display("[TB] FAIL bus_write_timeout addr=%h ready=%b wanted ready=1", a, ready);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        sel = 1'b0; rw = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] got, output int st);
        st = 0;
        sel = 1'b1; rw = 1'b0; addr = a; data_wr = '0;
        #1;
        while (ready !== 1'b1 && st < 200) begin
            st++;
            @(negedge clk); #1;
        end
        got = data_rd;
        if (st >= 200) begin
            total++; bad++;
            $display("[TB] FAIL bus_read_timeout addr=%h ready=%b wanted ready=1", a, ready);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic wr(input int c, input logic [3:0] off, input logic [31:0] d, output int st);
        bus_write(ra(c, off), d, st);
        mdl_write(c, off, d);
    endtask

    task automatic test_reset();
        logic [31:0] lit[4] = '{32'hFFFF_FFFF, 32'h0000_1021, 32'h0, 32'h0};
        logic [31:0] got, exp;
        string nm;
        int st;
        rst = 1'b0; sel = 1'b1; rw = 1'b0; addr = ra(0, 4'h0);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (ready !== 1'b1) begin bad++; $display("[TB] FAIL in_reset_ready got=%b want=1", ready); end
        total++;
        if (data_rd !== 32'h0) begin bad++; $display("[TB] FAIL in_reset_rd got=%h want=0", data_rd); end
        @(negedge clk);
        rst = 1'b1; sel = 1'b0;
        mdl_reset();
        #1;
        total++;
        if (data_rd !== 32'h0 || ready !== 1'b1) begin
            bad++; $display("[TB] FAIL unselected got rd=%h rdy=%b want rd=0 rdy=1", data_rd, ready);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(lit[k]);
            name_q.push_back($sformatf("reset_ctx0_off%0h", 4 * k));
        end
        for (int k = 0; k < 4; k++) begin
            bus_read(ra(0, 4'(4 * k)), got, st);
            exp = exp_q.pop_front(); nm = name_q.pop_front();
            total++;
            if (st !== 0) begin bad++; $display("[TB] FAIL %s_stall got=%0d want=0", nm, st); end
            total++;
            if (got !== exp) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, got, exp); end
        end
    endtask

    task automatic test_seed16();
        logic [31:0] got, exp;
        string nm;
        int st;
        wr(1, 4'h8, 32'h0200_0000, st);
        wr(1, 4'h0, 32'h0000_0000, st);
        wr(1, 4'h8, 32'h0000_0000, st);
        wr(1, 4'h0, 32'h0001_0000, st);
        exp_q.push_back(32'h0000_1021); name_q.push_back("seed16_data");
        exp_q.push_back(32'h0001_0000); name_q.push_back("seed16_status");
        bus_read(ra(1, 4'h0), got, st);
        exp = exp_q.pop_front(); nm = name_q.pop_front();
        total++;
        if (st !== LAT) begin bad++; $display("[TB] FAIL seed16_stall got=%0d want=%0d", st, LAT); end
        total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, got, exp); end
        bus_read(ra(1, 4'hC), got, st);
        exp = exp_q.pop_front(); nm = name_q.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, got, exp); end
    endtask

    task automatic test_crc32_and_transpose();
        logic [31:0] got, exp;
        string nm;
        int st;
        wr(2, 4'h4, 32'h04C1_1DB7, st);
        wr(2, 4'h8, 32'h0300_0000, st);
        wr(2, 4'h0, 32'h0000_0000, st);
        wr(2, 4'h8, 32'h0100_0000, st);
        wr(2, 4'h0, 32'h0000_0001, st);
        exp_q.push_back(32'h0000_0001); name_q.push_back("crc32_plain");
        bus_read(ra(2, 4'h0), got, st);
        exp = exp_q.pop_front(); nm = name_q.pop_front();
        total++;
        if (st !== LAT) begin bad++; $display("[TB] FAIL crc32_stall got=%0d want=%0d", st, LAT); end
        total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, got, exp); end

        wr(2, 4'h8, 32'h0500_0000, st);
        exp_q.push_back(32'hFFFF_FFFE); name_q.push_back("crc32_fxor");
        bus_read(ra(2, 4'h0), got, st);
        exp = exp_q.pop_front(); nm = name_q.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, got, exp); end

        wr(2, 4'h8, 32'h2100_0000, st);
        exp_q.push_back(32'h8000_0000); name_q.push_back("crc32_totr_rev");
        exp_q.push_back(32'h2100_0000); name_q.push_back("crc32_ctrl_readback");
        bus_read(ra(2, 4'h0), got, st);
        exp = exp_q.pop_front(); nm = name_q.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, got, exp); end
        bus_read(ra(2, 4'h8), got, st);
        exp = exp_q.pop_front(); nm = name_q.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, got, exp); end

        wr(3, 4'h8, 32'hC300_0000, st);
        wr(3, 4'h0, 32'h1122_3344, st);
        wr(3, 4'h8, 32'h0100_0000, st);
        exp_q.push_back(32'h4433_2211); name_q.push_back("tot_byteswap_seed");
        bus_read(ra(3, 4'h0), got, st);
        exp = exp_q.pop_front(); nm = name_q.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, got, exp); end

        wr(3, 4'h8, 32'h4300_0000, st);
        wr(3, 4'h0, 32'h0102_0304, st);
        wr(3, 4'h8, 32'h3100_0000, st);
        exp_q.push_back(32'h20C0_4080); name_q.push_back("tot_bitrev_totr_swap");
        bus_read(ra(3, 4'h0), got, st);
        exp = exp_q.pop_front(); nm = name_q.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, got, exp); end

        bus_write(BASE + 32'h44, 32'h5555_5555, st);
        exp_q.push_back(32'h0); name_q.push_back("unmapped_above");
        exp_q.push_back(32'h0); name_q.push_back("unmapped_unaligned");
        bus_read(BASE + 32'h40, got, st);
        exp = exp_q.pop_front(); nm = name_q.pop_front();
        total++;
        if (got !== exp || st !== 0) begin bad++; $display("[TB] FAIL %s got=%h stall=%0d want=%h stall=0", nm, got, st, exp); end
        bus_read(BASE + 32'h2, got, st);
        exp = exp_q.pop_front(); nm = name_q.pop_front();
        total++;
        if (got !== exp || st !== 0) begin bad++; $display("[TB] FAIL %s got=%h stall=%0d want=%h stall=0", nm, got, st, exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, exp;
        string nm;
        int s0, s1, s2, st;
        logic [15:0] c1pre, c2pre;
        c1pre = m_cnt[1];
        c2pre = m_cnt[2];
        wr(0, 4'h0, 32'hA5A5_0F0F, s0);
        wr(1, 4'h0, 32'h1357_9BDF, s1);
        wr(2, 4'h0, 32'hDEAD_0001, s2);
        total++;
        if (s0 !== 0) begin bad++; $display("[TB] FAIL b2b_first_stall got=%0d want=0", s0); end
        total++;
        if (s1 !== 0) begin bad++; $display("[TB] FAIL b2b_second_stall got=%0d want=0", s1); end
        total++;
        if (s2 !== LAT - 1) begin bad++; $display("[TB] FAIL b2b_third_stall got=%0d want=%0d", s2, LAT - 1); end
        exp_q.push_back({c2pre, 16'h0002}); name_q.push_back("b2b_status2_pending");
        exp_q.push_back({c1pre, 16'h0001}); name_q.push_back("b2b_status1_busy");
        bus_read(ra(2, 4'hC), got, st);
        exp = exp_q.pop_front(); nm = name_q.pop_front();
        total++;
        if (got !== exp || st !== 0) begin bad++; $display("[TB] FAIL %s got=%h stall=%0d want=%h stall=0", nm, got, st, exp); end
        bus_read(ra(1, 4'hC), got, st);
        exp = exp_q.pop_front(); nm = name_q.pop_front();
        total++;
        if (got !== exp || st !== 0) begin bad++; $display("[TB] FAIL %s got=%h stall=%0d want=%h stall=0", nm, got, st, exp); end

        wr(3, 4'h4, 32'hDEAD_BEEF, st);
        total++;
        if (st !== 0) begin bad++; $display("[TB] FAIL b2b_ctx3_poly_wr_stall got=%0d want=0", st); end
        exp_q.push_back(32'hDEAD_BEEF); name_q.push_back("b2b_ctx3_poly");
        bus_read(ra(3, 4'h4), got, st);
        exp = exp_q.pop_front(); nm = name_q.pop_front();
        total++;
        if (got !== exp || st !== 0) begin bad++; $display("[TB] FAIL %s got=%h stall=%0d want=%h stall=0", nm, got, st, exp); end

        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(mdl_read(c, 4'h0));
            name_q.push_back($sformatf("b2b_result_ctx%0d", c));
        end
        for (int c = 0; c < 3; c++) begin
            bus_read(ra(c, 4'h0), got, st);
            exp = exp_q.pop_front(); nm = name_q.pop_front();
            total++;
            if (got !== exp) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, got, exp); end
        end
    endtask

    task automatic test_serialise();
        logic [31:0] got, exp;
        string nm;
        int st;
        wr(0, 4'h4, 32'h04C1_1DB7, st);
        wr(0, 4'h8, 32'h0300_0000, st);
        wr(0, 4'h0, 32'hFFFF_FFFF, st);
        wr(0, 4'h8, 32'h0100_0000, st);
        wr(0, 4'h0, 32'h1234_5678, st);
        total++;
        if (st !== 0) begin bad++; $display("[TB] FAIL ser_first_stall got=%0d want=0", st); end
        wr(0, 4'h0, 32'h9ABC_DEF0, st);
        total++;
        if (st !== LAT) begin bad++; $display("[TB] FAIL ser_second_stall got=%0d want=%0d", st, LAT); end
        exp_q.push_back(mdl_read(0, 4'h0)); name_q.push_back("ser_result");
        exp_q.push_back(32'h0002_0000);     name_q.push_back("ser_status");
        bus_read(ra(0, 4'h0), got, st);
        exp = exp_q.pop_front(); nm = name_q.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, got, exp); end
        bus_read(ra(0, 4'hC), got, st);
        exp = exp_q.pop_front(); nm = name_q.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("[TB] FAIL %s got=%h want=%h", nm, got, exp); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] lit[4] = '{32'hFFFF_FFFF, 32'h0000_1021, 32'h0, 32'h0};
        logic [31:0] got, exp;
        string nm;
        int st;
        wr(3, 4'h8, 32'h0100_0000, st);
        wr(3, 4'h0, 32'hCAFE_F00D, st);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0; sel = 1'b1; rw = 1'b0; addr = ra(3, 4'h0);
        #1;
        total++;
        if (ready !== 1'b1 || data_rd !== 32'h0) begin
            bad++; $display("[TB] FAIL midrun_reset_outputs got rdy=%b rd=%h want rdy=1 rd=0", ready, data_rd);
        end
        @(negedge clk);
        rst = 1'b1; sel = 1'b0;
        mdl_reset();
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back(lit[k]);
                name_q.push_back($sformatf("after_reset_ctx%0d_off%0h", c, 4 * k));
                bus_read(ra(c, 4'(4 * k)), got, st);
                exp = exp_q.pop_front(); nm = name_q.pop_front();
                total++;
                if (got !== exp || st !== 0) begin
                    bad++; $display("[TB] FAIL %s got=%h stall=%0d want=%h stall=0", nm, got, st, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_seed16();
        test_crc32_and_transpose();
        test_back_to_back();
        test_serialise();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

endmodule
